// File: rtl/gmii_tx_framer_if.sv
// Byte-stream payload handshake feeding the GMII transmit framer.
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad to minimum length,
// CRC-32 FCS, inter-frame gap, and underrun abort with drain to end of frame.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic             gmii_tx_clk,
  input  logic             rst,
  gmii_tx_framer_if.slave  s,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [7:0]       gmii_txd,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      r_state;
  logic [31:0] r_crc;
  logic [15:0] r_byte_cnt;
  logic [7:0]  r_cnt;
  logic        r_tx_en;
  logic        r_tx_er;
  logic [7:0]  r_txd;
  logic        r_frame_done;
  logic        r_underrun;

  logic        w_ready;
  logic [15:0] w_bc_inc;
  logic [31:0] w_fcs;

  assign w_ready  = (r_state == S_SFD) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign w_bc_inc = sat_inc(r_byte_cnt);
  assign w_fcs    = ~r_crc;

  assign s.s_ready  = w_ready;
  assign gmii_tx_en = r_tx_en;
  assign gmii_tx_er = r_tx_er;
  assign gmii_txd   = r_txd;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  // State names the decision being made this cycle; gmii outputs show the
  // byte chosen on the previous edge, so a byte accepted at k appears at k+1.
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_crc        <= 32'hFFFFFFFF;
      r_byte_cnt   <= 16'd0;
      r_cnt        <= 8'd0;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_txd        <= 8'h00;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_tx_er      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_crc      <= 32'hFFFFFFFF;
          r_byte_cnt <= 16'd0;
          r_cnt      <= 8'd0;
          r_tx_en    <= 1'b0;
          r_txd      <= 8'h00;
          if (s.s_valid) begin
            r_state <= S_PRE;
            r_tx_en <= 1'b1;
            r_txd   <= 8'h55;
            r_cnt   <= 8'd1;
          end
        end
        S_PRE: begin
          if (r_cnt >= 8'(PREAMBLE_LEN)) begin
            r_state <= S_SFD;
            r_txd   <= 8'hD5;
          end else begin
            r_txd <= 8'h55;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SFD, S_DATA: begin
          if (s.s_valid) begin
            r_txd      <= s.s_data;
            r_crc      <= crc_next(r_crc, s.s_data);
            r_byte_cnt <= w_bc_inc;
            r_cnt      <= 8'd0;
            if (s.s_last)
              r_state <= (w_bc_inc < 16'(MIN_FRAME)) ? S_PAD : S_FCS;
            else
              r_state <= S_DATA;
          end else begin
            r_txd      <= 8'h00;
            r_tx_er    <= 1'b1;
            r_underrun <= 1'b1;
            r_state    <= S_DRAIN;
          end
        end
        S_PAD: begin
          r_txd      <= 8'h00;
          r_crc      <= crc_next(r_crc, 8'h00);
          r_byte_cnt <= w_bc_inc;
          if (w_bc_inc >= 16'(MIN_FRAME))
            r_state <= S_FCS;
        end
        S_FCS: begin
          r_cnt <= r_cnt + 8'd1;
          case (r_cnt)
            8'd0:    r_txd <= w_fcs[7:0];
            8'd1:    r_txd <= w_fcs[15:8];
            8'd2:    r_txd <= w_fcs[23:16];
            8'd3:    r_txd <= w_fcs[31:24];
            default: begin
              r_tx_en      <= 1'b0;
              r_txd        <= 8'h00;
              r_frame_done <= 1'b1;
              r_cnt        <= 8'd1;
              r_state      <= S_IFG;
            end
          endcase
        end
        S_DRAIN: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          if (s.s_valid && s.s_last) begin
            r_cnt   <= 8'd1;
            r_state <= S_IFG;
          end
        end
        S_IFG: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          if (r_cnt >= 8'(IFG_CYCLES - 1))
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table of frame scenarios, randomized frames against
// a lookup-table CRC frame model, reset abort, and a MIN_FRAME=0 check value.
module tb_gmii_tx_framer;
  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  gmii_tx_framer_if bus ();
  gmii_tx_framer_if bus0 ();

  logic       en, er, busy, done, und;
  logic [7:0] txd;
  logic       en0, er0, busy0, done0, und0;
  logic [7:0] txd0;

  gmii_tx_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MINF), .IFG_CYCLES(IFG)) u_dut (
    .gmii_tx_clk(clk), .rst(rst), .s(bus),
    .gmii_tx_en(en), .gmii_tx_er(er), .gmii_txd(txd),
    .busy(busy), .frame_done(done), .underrun(und));

  gmii_tx_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(0), .IFG_CYCLES(IFG)) u_dut0 (
    .gmii_tx_clk(clk), .rst(rst), .s(bus0),
    .gmii_tx_en(en0), .gmii_tx_er(er0), .gmii_txd(txd0),
    .busy(busy0), .frame_done(done0), .underrun(und0));

  typedef struct {logic en, er, und, done, busy; logic [7:0] txd;} samp_t;
  typedef struct {logic v, last; logic [7:0] d;} beat_t;
  typedef struct {int len; int stall; int n; int exp_en; int exp_done; int exp_und;} vec_t;

  int          errors = 0;
  int          checks = 0;
  samp_t       cap[$];
  beat_t       beats[$];
  bit          presenting, prev_ready;
  int          ph_len[$], ph_stall[$];
  logic [7:0]  ph_bytes[$];
  logic [9:0]  exp_run[$];
  logic [31:0] crc_tab[256];
  vec_t        vt[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic init_crc();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  function automatic logic [31:0] ref_crc(input int off, input int len, input int n);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = (i < len) ? ph_bytes[off + i] : 8'h00;
      c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
    end
    return c;
  endfunction

  // One clock: retire the beat taken at the last edge, sample, present next beat.
  task automatic step();
    samp_t sm;
    @(negedge clk);
    if (presenting && prev_ready) void'(beats.pop_front());
    sm.en = en; sm.er = er; sm.und = und; sm.done = done; sm.busy = busy; sm.txd = txd;
    cap.push_back(sm);
    if (beats.size() > 0) begin
      bus.s_valid = beats[0].v; bus.s_data = beats[0].d; bus.s_last = beats[0].last;
      presenting = 1'b1;
    end else begin
      bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
      presenting = 1'b0;
    end
    prev_ready = bus.s_ready;
  endtask

  task automatic push_frame(input int len, input int stall, input int pat);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = (pat == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      ph_bytes.push_back(b);
      if (stall == i) beats.push_back('{v: 1'b0, last: 1'b0, d: 8'h00});
      beats.push_back('{v: 1'b1, last: (i == len - 1), d: b});
    end
    ph_len.push_back(len);
    ph_stall.push_back(stall);
  endtask

  task automatic clear_phase();
    ph_len.delete(); ph_stall.delete(); ph_bytes.delete();
  endtask

  // Expected tx_en-high run as {underrun, tx_er, txd} per cycle.
  task automatic build_exp(input int f, input int off);
    int n;
    logic [31:0] fcs;
    exp_run.delete();
    for (int i = 0; i < PRE; i++) exp_run.push_back({2'b00, 8'h55});
    exp_run.push_back({2'b00, 8'hD5});
    if (ph_stall[f] < 0) begin
      n = (ph_len[f] > MINF) ? ph_len[f] : MINF;
      for (int i = 0; i < n; i++)
        exp_run.push_back({2'b00, (i < ph_len[f]) ? ph_bytes[off + i] : 8'h00});
      fcs = ~ref_crc(off, ph_len[f], n);
      for (int k = 0; k < 4; k++) exp_run.push_back({2'b00, fcs[8*k +: 8]});
    end else begin
      for (int i = 0; i < ph_stall[f]; i++) exp_run.push_back({2'b00, ph_bytes[off + i]});
      exp_run.push_back({2'b11, 8'h00});
    end
  endtask

  task automatic run_phase();
    int bound = 0;
    cap.delete();
    while (beats.size() > 0 && bound < 20000) begin
      step();
      bound++;
    end
    if (beats.size() > 0) begin
      check("stream drain timeout", beats.size(), 0);
      beats.delete();
    end
    repeat (100) step();
  endtask

  task automatic check_phase(input string nm, input int exp_en, input int exp_done, input int exp_und);
    int rs[$], re[$];
    int n_en = 0, n_done = 0, n_und = 0, n_nobusy = 0;
    int off = 0, good = 0, bad = 0, done_ok = 0, mism, glen, egap;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i].en) begin
        n_en++;
        if (!cap[i].busy) n_nobusy++;
        if (i == 0 || !cap[i-1].en) rs.push_back(i);
        if (i == cap.size() - 1 || !cap[i+1].en) re.push_back(i);
      end
      if (cap[i].done) n_done++;
      if (cap[i].und) n_und++;
    end
    check($sformatf("%s run count", nm), rs.size(), ph_len.size());
    for (int f = 0; f < ph_len.size(); f++) begin
      build_exp(f, off);
      if (f < rs.size()) begin
        glen = re[f] - rs[f] + 1;
        mism = -1;
        for (int j = 0; j < glen && j < exp_run.size(); j++)
          if (mism < 0 && {cap[rs[f]+j].und, cap[rs[f]+j].er, cap[rs[f]+j].txd} !== exp_run[j])
            mism = j;
        check($sformatf("%s f%0d run length", nm, f), glen, exp_run.size());
        check($sformatf("%s f%0d first bad byte index", nm, f), mism, -1);
        if (ph_stall[f] < 0 && re[f] + 1 < cap.size() && cap[re[f]+1].done) done_ok++;
        if (f > 0) begin
          egap = (ph_stall[f-1] < 0) ? IFG : (ph_len[f-1] - ph_stall[f-1] - 1 + IFG);
          check($sformatf("%s f%0d gap", nm, f), rs[f] - re[f-1] - 1, egap);
        end
      end
      if (ph_stall[f] < 0) good++; else bad++;
      off += ph_len[f];
    end
    if (exp_en >= 0) check($sformatf("%s tx_en cycles", nm), n_en, exp_en);
    check($sformatf("%s frame_done pulses", nm), n_done, (exp_done >= 0) ? exp_done : good);
    check($sformatf("%s frame_done placement", nm), done_ok, good);
    check($sformatf("%s underrun pulses", nm), n_und, (exp_und >= 0) ? exp_und : bad);
    check($sformatf("%s busy low while sending", nm), n_nobusy, 0);
    check($sformatf("%s idle at end", nm), {cap[cap.size()-1].busy, cap[cap.size()-1].en}, 0);
    clear_phase();
  endtask

  task automatic run_min0();
    string      str = "123456789";
    logic [7:0] got[$];
    int         idx = 0;
    bit         acc = 1'b0, seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (en0) got.push_back(txd0);
      if (done0) seen_done = 1'b1;
      if (acc) idx++;
      if (idx < 9) begin
        bus0.s_valid = 1'b1; bus0.s_data = str[idx]; bus0.s_last = (idx == 8);
      end else begin
        bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0;
      end
      acc = (idx < 9) && bus0.s_ready;
    end
    check("min0 run length", got.size(), 21);
    if (got.size() >= 21) begin
      check("min0 payload first/last", {got[8], got[16]}, {8'h31, 8'h39});
      check("min0 fcs bytes", {got[17], got[18], got[19], got[20]}, 32'h2639F4CB);
    end
    check("min0 frame_done", seen_done, 1);
  endtask

  initial begin
    int ne;
    int len, stall;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0;
    presenting = 1'b0; prev_ready = 1'b0;
    init_crc();
    repeat (3) @(negedge clk);
    check("reset tx_en/tx_er", {en, er}, 0);
    check("reset txd", txd, 0);
    check("reset busy/done/underrun/ready", {busy, done, und, bus.s_ready}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    vt.push_back('{60, -1, 1, 72, 1, 0});
    vt.push_back('{14, -1, 1, 72, 1, 0});
    vt.push_back('{1, -1, 1, 72, 1, 0});
    vt.push_back('{100, -1, 1, 112, 1, 0});
    vt.push_back('{60, -1, 2, 144, 2, 0});
    vt.push_back('{60, 20, 1, 29, 0, 1});
    vt.push_back('{60, 20, 2, 101, 1, 1});
    vt.push_back('{61, 60, 2, 142, 1, 1});
    for (int r = 0; r < vt.size(); r++) begin
      for (int f = 0; f < vt[r].n; f++)
        push_frame(vt[r].len, (f == 0) ? vt[r].stall : -1, (r == 0) ? 0 : 1);
      run_phase();
      check_phase($sformatf("vec%0d", r), vt[r].exp_en, vt[r].exp_done, vt[r].exp_und);
    end

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(2, 90);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      push_frame(len, stall, 1);
    end
    run_phase();
    check_phase("random", -1, -1, -1);

    // Reset while the 30th payload byte is on the wire.
    cap.delete();
    push_frame(60, -1, 0);
    ne = 0;
    for (int c = 0; c < 400 && ne < 38; c++) begin
      step();
      if (cap[cap.size()-1].en) ne++;
    end
    check("reached 30th byte", ne, 38);
    check("30th byte value", cap[cap.size()-1].txd, 29);
    #1 rst = 1'b1;
    #1;
    check("mid-frame reset tx_en/txd", {en, er, txd}, 0);
    check("mid-frame reset busy/ready", {busy, bus.s_ready}, 0);
    beats.delete(); clear_phase();
    presenting = 1'b0; prev_ready = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_frame(60, -1, 1);
    run_phase();
    check_phase("post-reset", 72, 1, 0);

    run_min0();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
